// File: rtl/ins_cache_nway.sv
// ins_cache_nway: clocked N-way set-associative instruction cache model with
// true LRU, a single outstanding miss toward the next level and saturating
// hit/miss/read statistics. Only tags and state are modelled, not line data.
//
// Handshakes: a command transfers on a rising edge where req_valid and
// req_ready are both high (req_ready is high only while idle). A line request
// transfers on an edge where mem_req_valid and mem_req_ready are both high;
// mem_req_valid and mem_addr stay stable until then. mem_resp_valid is a
// one-cycle fill notification and is honoured only while waiting for a fill.
module ins_cache_nway #(
  parameter int ADDR_W      = 32,
  parameter int OFFSET_BITS = 6,
  parameter int INDEX_BITS  = 14,
  parameter int WAYS        = 4,
  parameter int CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_cmd,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              resp_valid,
  output logic              resp_hit,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_resp_valid,
  output logic [CNT_W-1:0]  hits,
  output logic [CNT_W-1:0]  misses,
  output logic [CNT_W-1:0]  reads,
  output logic [2:0]        fsm_state
);

  localparam int TAG_W  = ADDR_W - INDEX_BITS - OFFSET_BITS;
  localparam int LINE_W = ADDR_W - OFFSET_BITS;
  localparam int SETS   = 1 << INDEX_BITS;
  localparam int WAY_W  = $clog2(WAYS);

  localparam logic [3:0] CMD_CLEAR = 4'd8;
  localparam logic [3:0] CMD_INV   = 4'd3;
  localparam logic [3:0] CMD_FETCH = 4'd2;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOOKUP    = 3'd1,
    S_MISS_REQ  = 3'd2,
    S_MISS_WAIT = 3'd3,
    S_FILL      = 3'd4
  } state_t;

  state_t state;

  // Latched command and line address (offset bits are never needed).
  logic [3:0]        cmd_q;
  logic [LINE_W-1:0] line_q;

  // Per-set storage.
  logic              valid_q [SETS][WAYS];
  logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
  logic [WAY_W-1:0]  age_q   [SETS][WAYS];

  logic [INDEX_BITS-1:0] idx;
  logic [TAG_W-1:0]      tag_in;
  logic                  hit;
  logic [WAY_W-1:0]      hit_way;
  logic [WAY_W-1:0]      victim_way;
  logic                  in_lookup;
  logic                  wipe;
  logic                  touch_en;
  logic [WAY_W-1:0]      touch_way;
  logic                  unused_offset;

  assign idx           = line_q[INDEX_BITS-1:0];
  assign tag_in        = line_q[LINE_W-1 -: TAG_W];
  assign req_ready     = (state == S_IDLE);
  assign fsm_state     = state;
  assign unused_offset = ^req_addr[OFFSET_BITS-1:0];

  assign in_lookup = (state == S_LOOKUP);
  // CLEAR wipes the arrays exactly as reset does.
  assign wipe      = !rst_n || (in_lookup && cmd_q == CMD_CLEAR);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Tag match across the ways of the addressed set.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[idx][w] && tag_q[idx][w] == tag_in) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  // Victim: lowest-numbered invalid way, otherwise the least recently used one.
  always_comb begin
    victim_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (age_q[idx][w] == WAY_W'(WAYS - 1)) victim_way = WAY_W'(w);
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[idx][w]) victim_way = WAY_W'(w);
    end
  end

  // Way whose recency is refreshed this cycle: a FETCH hit or the filled way.
  always_comb begin
    touch_en  = 1'b0;
    touch_way = '0;
    if (in_lookup && cmd_q == CMD_FETCH && hit) begin
      touch_en  = 1'b1;
      touch_way = hit_way;
    end else if (state == S_FILL) begin
      touch_en  = 1'b1;
      touch_way = victim_way;
    end
  end

  // Tag/valid/age arrays: wipe, invalidate, fill and LRU aging.
  always_ff @(posedge clk) begin
    if (wipe) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          age_q[s][w]   <= WAY_W'(w);
        end
      end
    end else begin
      if (in_lookup && cmd_q == CMD_INV && hit) begin
        valid_q[idx][hit_way] <= 1'b0;
      end
      if (state == S_FILL) begin
        tag_q[idx][victim_way]   <= tag_in;
        valid_q[idx][victim_way] <= 1'b1;
      end
      if (touch_en) begin
        // Ways younger than the touched one age by one; it becomes youngest.
        for (int v = 0; v < WAYS; v++) begin
          if (age_q[idx][v] < age_q[idx][touch_way]) begin
            age_q[idx][v] <= age_q[idx][v] + 1'b1;
          end
        end
        age_q[idx][touch_way] <= '0;
      end
    end
  end

  // Control FSM, response pulse, next-level request and statistics.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      cmd_q         <= '0;
      line_q        <= '0;
      resp_valid    <= 1'b0;
      resp_hit      <= 1'b0;
      mem_req_valid <= 1'b0;
      mem_addr      <= '0;
      hits          <= '0;
      misses        <= '0;
      reads         <= '0;
    end else begin
      resp_valid <= 1'b0;
      resp_hit   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            cmd_q  <= req_cmd;
            line_q <= req_addr[ADDR_W-1:OFFSET_BITS];
            if (req_cmd == CMD_CLEAR || req_cmd == CMD_INV || req_cmd == CMD_FETCH) begin
              state <= S_LOOKUP;
            end
          end
        end
        S_LOOKUP: begin
          state <= S_IDLE;
          case (cmd_q)
            CMD_CLEAR: begin
              hits       <= '0;
              misses     <= '0;
              reads      <= '0;
              resp_valid <= 1'b1;
            end
            CMD_INV: begin
              resp_valid <= 1'b1;
              resp_hit   <= hit;
            end
            CMD_FETCH: begin
              reads <= sat_inc(reads);
              if (hit) begin
                hits       <= sat_inc(hits);
                resp_valid <= 1'b1;
                resp_hit   <= 1'b1;
              end else begin
                misses        <= sat_inc(misses);
                mem_req_valid <= 1'b1;
                mem_addr      <= {line_q, {OFFSET_BITS{1'b0}}};
                state         <= S_MISS_REQ;
              end
            end
            default: ;
          endcase
        end
        S_MISS_REQ: begin
          // A fill notification here is premature and deliberately ignored.
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= S_MISS_WAIT;
          end
        end
        S_MISS_WAIT: begin
          if (mem_resp_valid) state <= S_FILL;
        end
        S_FILL: begin
          resp_valid <= 1'b1;
          resp_hit   <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ins_cache_nway.sv
// tb_ins_cache_nway: directed and randomized checks of ins_cache_nway against
// a recency-list reference model (per set: resident tags, most recent first).
module tb_ins_cache_nway;

  localparam int ADDR_W      = 32;
  localparam int OFFSET_BITS = 6;
  localparam int INDEX_BITS  = 4;
  localparam int WAYS        = 4;
  localparam int CNT_W       = 4;
  localparam int SETS        = 1 << INDEX_BITS;
  localparam int CMAX        = (1 << CNT_W) - 1;

  localparam logic [3:0] CMD_CLEAR = 4'd8;
  localparam logic [3:0] CMD_INV   = 4'd3;
  localparam logic [3:0] CMD_FETCH = 4'd2;

  logic              clk;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic [3:0]        req_cmd;
  logic [ADDR_W-1:0] req_addr;
  logic              resp_valid;
  logic              resp_hit;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_resp_valid;
  logic [CNT_W-1:0]  hits;
  logic [CNT_W-1:0]  misses;
  logic [CNT_W-1:0]  reads;
  logic [2:0]        fsm_state;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  int unsigned lines [SETS][$];
  int m_hits, m_misses, m_reads;
  logic last_hit;

  ins_cache_nway #(
    .ADDR_W(ADDR_W), .OFFSET_BITS(OFFSET_BITS), .INDEX_BITS(INDEX_BITS),
    .WAYS(WAYS), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_hit(resp_hit),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_resp_valid(mem_resp_valid),
    .hits(hits), .misses(misses), .reads(reads), .fsm_state(fsm_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk_addr(input int tag, input int index, input int off);
    return 32'((tag << (INDEX_BITS + OFFSET_BITS)) | (index << OFFSET_BITS) | off);
  endfunction

  // ---------------- reference model ----------------
  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  task automatic model_clear();
    for (int s = 0; s < SETS; s++) lines[s].delete();
    m_hits = 0; m_misses = 0; m_reads = 0;
  endtask

  task automatic model_fetch(input logic [31:0] addr, output logic exp_hit);
    int unsigned q[$];
    int unsigned tag;
    int s;
    int pos;
    tag = addr >> (INDEX_BITS + OFFSET_BITS);
    s   = int'((addr >> OFFSET_BITS) % SETS);
    q   = lines[s];
    pos = -1;
    foreach (q[i]) if (q[i] == tag) pos = i;
    m_reads = sat(m_reads);
    if (pos >= 0) begin
      exp_hit = 1'b1;
      m_hits  = sat(m_hits);
      q.delete(pos);
    end else begin
      exp_hit  = 1'b0;
      m_misses = sat(m_misses);
      if (q.size() == WAYS) void'(q.pop_back());
    end
    q.push_front(tag);
    lines[s] = q;
  endtask

  task automatic model_inv(input logic [31:0] addr, output logic exp_hit);
    int unsigned q[$];
    int unsigned tag;
    int s;
    int pos;
    tag = addr >> (INDEX_BITS + OFFSET_BITS);
    s   = int'((addr >> OFFSET_BITS) % SETS);
    q   = lines[s];
    pos = -1;
    foreach (q[i]) if (q[i] == tag) pos = i;
    exp_hit = (pos >= 0);
    if (pos >= 0) q.delete(pos);
    lines[s] = q;
  endtask

  // ---------------- driver ----------------
  // Issues one command and plays the next level. Reports whether a response
  // came, its hit flag and latency (cycles after the accept edge), the first
  // miss address seen, whether a line request appeared at all, and whether
  // request/ready behaviour stayed well-formed while waiting.
  task automatic run_cmd(input logic [3:0] cmd, input logic [31:0] addr,
                         input int rdy_dly, input int rsp_dly, input bit noise,
                         output logic got, output logic hit, output int lat,
                         output logic [31:0] maddr, output logic memreq, output logic stable);
    int phase;
    int cnt;
    got = 0; hit = 0; lat = 0; maddr = 0; memreq = 0; stable = 1; phase = 0; cnt = 0;
    @(negedge clk);
    if (!req_ready) stable = 0;
    req_valid = 1'b1; req_cmd = cmd; req_addr = addr;
    @(negedge clk);
    req_valid = 1'b0; req_cmd = 4'($urandom); req_addr = $urandom;
    for (int n = 1; n <= 80 && !got; n++) begin
      mem_resp_valid = 1'b0;
      if (resp_valid) begin
        got = 1; hit = resp_hit; lat = n;
      end else begin
        if (req_ready) stable = 0;
        if (phase == 0 && mem_req_valid) begin
          phase = 1; maddr = mem_addr; cnt = 0; memreq = 1;
        end
        if (phase == 1) begin
          if (!mem_req_valid || mem_addr !== maddr) stable = 0;
          if (noise) mem_resp_valid = 1'($urandom);
          if (cnt >= rdy_dly) begin
            mem_req_ready = 1'b1;
            if (noise) mem_resp_valid = 1'b1;
            phase = 2; cnt = 0;
          end else cnt++;
        end else if (phase == 2) begin
          mem_req_ready = 1'b0;
          if (mem_req_valid) stable = 0;
          if (cnt >= rsp_dly) begin
            mem_resp_valid = 1'b1; phase = 3;
          end else cnt++;
        end else if (phase == 3) begin
          if (mem_req_valid) stable = 0;
        end
      end
      @(negedge clk);
    end
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
  endtask

  task automatic check_counters(input string name);
    check({name, "_hits"},   32'(hits),   32'(m_hits));
    check({name, "_misses"}, 32'(misses), 32'(m_misses));
    check({name, "_reads"},  32'(reads),  32'(m_reads));
  endtask

  task automatic do_fetch(input logic [31:0] addr, input int rdy, input int rsp, input bit noise);
    logic exp_hit, got, hit, memreq, stable;
    int lat;
    logic [31:0] maddr;
    model_fetch(addr, exp_hit);
    run_cmd(CMD_FETCH, addr, rdy, rsp, noise, got, hit, lat, maddr, memreq, stable);
    last_hit = hit;
    check("fetch_resp", 32'(got), 32'(1));
    check("fetch_hit", 32'(hit), 32'(exp_hit));
    check("fetch_lat", 32'(lat), exp_hit ? 32'(2) : 32'(5 + rdy + rsp));
    check("fetch_memreq", 32'(memreq), 32'(!exp_hit));
    check("fetch_stable", 32'(stable), 32'(1));
    if (!exp_hit) check("fetch_mem_addr", maddr, addr & ~32'((1 << OFFSET_BITS) - 1));
    check_counters("fetch");
  endtask

  task automatic do_inv(input logic [31:0] addr);
    logic exp_hit, got, hit, memreq, stable;
    int lat;
    logic [31:0] maddr;
    model_inv(addr, exp_hit);
    run_cmd(CMD_INV, addr, 0, 0, 1'b0, got, hit, lat, maddr, memreq, stable);
    last_hit = hit;
    check("inv_resp", 32'(got), 32'(1));
    check("inv_hit", 32'(hit), 32'(exp_hit));
    check("inv_lat", 32'(lat), 32'(2));
    check("inv_memreq", 32'(memreq), 32'(0));
    check_counters("inv");
  endtask

  task automatic do_clear();
    logic got, hit, memreq, stable;
    int lat;
    logic [31:0] maddr;
    model_clear();
    run_cmd(CMD_CLEAR, $urandom, 0, 0, 1'b0, got, hit, lat, maddr, memreq, stable);
    check("clear_resp", 32'(got), 32'(1));
    check("clear_hit", 32'(hit), 32'(0));
    check("clear_lat", 32'(lat), 32'(2));
    check_counters("clear");
  endtask

  task automatic do_unknown(input logic [3:0] cmd);
    logic saw_resp, ready_all, saw_mreq;
    saw_resp = 0; ready_all = 1; saw_mreq = 0;
    @(negedge clk);
    req_valid = 1'b1; req_cmd = cmd; req_addr = $urandom;
    @(negedge clk);
    req_valid = 1'b0;
    for (int n = 0; n < 6; n++) begin
      if (resp_valid) saw_resp = 1;
      if (!req_ready) ready_all = 0;
      if (mem_req_valid) saw_mreq = 1;
      @(negedge clk);
    end
    check("unk_no_resp", 32'(saw_resp), 32'(0));
    check("unk_ready", 32'(ready_all), 32'(1));
    check("unk_no_mreq", 32'(saw_mreq), 32'(0));
    check_counters("unk");
  endtask

  // Stimulus
  initial begin
    logic [31:0] a;
    logic saw;
    int r;
    rst_n = 1'b0; req_valid = 1'b0; req_cmd = '0; req_addr = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("rst_req_ready", 32'(req_ready), 32'(1));
    check("rst_resp_valid", 32'(resp_valid), 32'(0));
    check("rst_resp_hit", 32'(resp_hit), 32'(0));
    check("rst_mem_req_valid", 32'(mem_req_valid), 32'(0));
    check("rst_mem_addr", mem_addr, 32'(0));
    check_counters("rst");

    // 1: cold miss with a 3-cycle fill, then hit on the same line.
    do_fetch(32'h0010_0000, 0, 3, 1'b0);
    do_fetch(32'h0010_0004, 0, 0, 1'b0);
    check("p1_rehit", 32'(last_hit), 32'(1));

    // 2: LRU eviction in set 0.
    do_clear();
    for (int t = 1; t <= 4; t++) do_fetch(mk_addr(t, 0, 0), t % 3, 1, 1'b0);
    do_fetch(mk_addr(1, 0, 8), 0, 0, 1'b0);
    do_fetch(mk_addr(5, 0, 0), 1, 0, 1'b1);
    do_fetch(mk_addr(2, 0, 0), 0, 2, 1'b0);
    check("p2_t2_evicted", 32'(last_hit), 32'(0));
    do_fetch(mk_addr(1, 0, 4), 0, 0, 1'b0);
    check("p2_t1_resident", 32'(last_hit), 32'(1));

    // 3: invalidate resident and absent lines.
    do_clear();
    do_fetch(32'h0010_0000, 0, 0, 1'b0);
    do_inv(32'h0010_0000);
    check("p3_inv_found", 32'(last_hit), 32'(1));
    do_fetch(32'h0010_0000, 0, 0, 1'b0);
    check("p3_refetch_miss", 32'(last_hit), 32'(0));
    do_inv(mk_addr(77, 3, 0));
    check("p3_inv_absent", 32'(last_hit), 32'(0));

    // 4: long request stall, then reset while waiting for the fill.
    do_clear();
    do_fetch(mk_addr(9, 2, 0), 10, 2, 1'b1);
    model_clear();
    a = mk_addr(11, 5, 12);
    @(negedge clk);
    req_valid = 1'b1; req_cmd = CMD_FETCH; req_addr = a;
    @(negedge clk);
    req_valid = 1'b0;
    for (int n = 0; n < 20 && !mem_req_valid; n++) @(negedge clk);
    check("p4_mreq_seen", 32'(mem_req_valid), 32'(1));
    check("p4_mem_addr", mem_addr, a & ~32'h3f);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    check("p4_wait_req_ready", 32'(req_ready), 32'(0));
    check("p4_wait_mreq_low", 32'(mem_req_valid), 32'(0));
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("p4_rst_req_ready", 32'(req_ready), 32'(1));
    check("p4_rst_mem_addr", mem_addr, 32'(0));
    check_counters("p4_rst");
    mem_resp_valid = 1'b1;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    saw = 0;
    for (int n = 0; n < 6; n++) begin
      if (resp_valid) saw = 1;
      @(negedge clk);
    end
    check("p4_late_fill_ignored", 32'(saw), 32'(0));
    check("p4_idle_after", 32'(req_ready), 32'(1));
    do_fetch(a, 0, 0, 1'b0);

    // 5: counter saturation, then CLEAR drops resident lines.
    do_clear();
    a = mk_addr(3, 7, 0);
    do_fetch(a, 0, 0, 1'b0);
    for (int n = 0; n < 17; n++) do_fetch(a | 32'($urandom_range(0, 63)), 0, 0, 1'b0);
    check("p5_hits_sat", 32'(hits), 32'(CMAX));
    do_clear();
    do_fetch(a, 0, 0, 1'b0);
    check("p5_clear_miss", 32'(last_hit), 32'(0));

    // 6: unknown commands.
    do_unknown(4'd5);
    do_unknown(4'd0);
    do_fetch(a, 0, 0, 1'b0);

    // Randomized mix over a few contended sets.
    do_clear();
    for (int n = 0; n < 60; n++) begin
      a = mk_addr($urandom_range(1, 6), $urandom_range(0, 2), $urandom_range(0, 63));
      r = $urandom_range(0, 99);
      if (r < 70) do_fetch(a, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
      else if (r < 90) do_inv(a);
      else if (r < 95) do_clear();
      else do_unknown(4'd15);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
